// File: rtl/sample_demux4.sv
// sample_demux4: steers one sample stream into four held channel registers, addressed or round-robin.
// One-cycle registered latency; DROP=0 stalls on a held target, DROP=1 never stalls and flags overwrites.
module sample_demux4 #(
  parameter int WIDTH = 24,
  parameter bit DROP  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             mode,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ack,
  output logic [3:0]       overflow,
  input  logic             clr_ovf,
  output logic [1:0]       rr_ptr
);

  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [3:0]       valid_q, valid_d;
  logic [3:0]       ovf_q, ovf_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       tgt;
  logic             xfer;

  always_comb begin
    tgt      = mode ? rr_q : in_sel;
    in_ready = DROP ? 1'b1 : (!valid_q[tgt] || out_ack[tgt]);
    xfer     = in_valid && in_ready;
    data_d   = data_q;
    valid_d  = valid_q & ~out_ack;
    ovf_d    = clr_ovf ? 4'b0000 : ovf_q;
    rr_d     = rr_q;
    if (xfer) begin
      data_d[tgt]  = in_data;
      valid_d[tgt] = 1'b1;
      // A same-cycle ack means the held sample was consumed, so it is not an overwrite.
      if (DROP && valid_q[tgt] && !out_ack[tgt]) begin
        ovf_d[tgt] = 1'b1;
      end
      if (mode) begin
        rr_d = rr_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= 4'b0000;
      ovf_q   <= 4'b0000;
      rr_q    <= 2'd0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      rr_q    <= rr_d;
    end
  end

  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign out_valid = valid_q;
  assign overflow  = ovf_q;
  assign rr_ptr    = rr_q;

endmodule

// File: tb/tb_sample_demux4.sv
// Bench for sample_demux4: a DROP=0 and a DROP=1 instance side by side, directed table plus random traffic.
module tb_sample_demux4;

  logic        clk = 1'b0;
  logic        rst;
  logic        t_vld  [2];
  logic [23:0] t_dat  [2];
  logic [1:0]  t_sel  [2];
  logic        t_mode [2];
  logic [3:0]  t_ack  [2];
  logic        t_clr  [2];
  logic        rdy    [2];
  logic [23:0] od     [2][4];
  logic [3:0]  ov     [2];
  logic [3:0]  of     [2];
  logic [1:0]  rp     [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sample_demux4 #(.WIDTH(24), .DROP(g == 1)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (t_vld[g]),
      .in_data  (t_dat[g]),
      .in_sel   (t_sel[g]),
      .mode     (t_mode[g]),
      .in_ready (rdy[g]),
      .out_data0(od[g][0]),
      .out_data1(od[g][1]),
      .out_data2(od[g][2]),
      .out_data3(od[g][3]),
      .out_valid(ov[g]),
      .out_ack  (t_ack[g]),
      .overflow (of[g]),
      .clr_ovf  (t_clr[g]),
      .rr_ptr   (rp[g])
    );
  end

  int total = 0;
  int bad   = 0;

  // Reference: per instance, what each channel holds, whether it is full, its overflow flag, next RR slot.
  logic [23:0] m_held [2][4];
  logic [3:0]  m_full [2];
  logic [3:0]  m_ovf  [2];
  int          m_ptr  [2];
  logic        m_rdy  [2];
  logic        rdy_seen [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 4; n++) m_held[d][n] = 24'h0;
      m_full[d] = 4'b0;
      m_ovf[d]  = 4'b0;
      m_ptr[d]  = 0;
    end
  endtask

  task automatic set_in(input int d, input logic v, input logic [23:0] dat, input logic [1:0] sel,
                        input logic md, input logic [3:0] ack, input logic clr);
    t_vld[d] = v; t_dat[d] = dat; t_sel[d] = sel; t_mode[d] = md; t_ack[d] = ack; t_clr[d] = clr;
  endtask

  // Called at posedge+1 with inputs already applied; returns at the following posedge+1.
  task automatic cyc();
    logic [1:0] tgt;
    logic       wasfull;
    #1;
    for (int d = 0; d < 2; d++) begin
      tgt = t_mode[d] ? 2'(m_ptr[d]) : t_sel[d];
      m_rdy[d] = (d == 1) || !m_full[d][tgt] || t_ack[d][tgt];
      rdy_seen[d] = rdy[d];
      chk($sformatf("in_ready[d%0d]", d), {31'b0, rdy[d]}, {31'b0, m_rdy[d]});
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      tgt = t_mode[d] ? 2'(m_ptr[d]) : t_sel[d];
      wasfull = m_full[d][tgt];
      if (t_clr[d]) m_ovf[d] = 4'b0;
      m_full[d] = m_full[d] & ~t_ack[d];
      if (t_vld[d] && m_rdy[d]) begin
        if (d == 1 && wasfull && !t_ack[d][tgt]) m_ovf[d][tgt] = 1'b1;
        m_held[d][tgt] = t_dat[d];
        m_full[d][tgt] = 1'b1;
        if (t_mode[d]) m_ptr[d] = (m_ptr[d] + 1) % 4;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("out_valid[d%0d]", d), {28'b0, ov[d]}, {28'b0, m_full[d]});
      chk($sformatf("overflow[d%0d]", d), {28'b0, of[d]}, {28'b0, m_ovf[d]});
      chk($sformatf("rr_ptr[d%0d]", d), {30'b0, rp[d]}, 32'(m_ptr[d]));
      for (int n = 0; n < 4; n++)
        chk($sformatf("out_data%0d[d%0d]", n, d), {8'b0, od[d][n]}, {8'b0, m_held[d][n]});
    end
  endtask

  typedef struct {
    int          d;
    logic        vld;
    logic [23:0] dat;
    logic [1:0]  sel;
    logic        md;
    logic [3:0]  ack;
    logic        clr;
    logic        e_rdy;
    logic [3:0]  e_vld;
    logic [3:0]  e_ovf;
    logic [1:0]  e_rr;
    int          e_ch;
    logic [23:0] e_dat;
  } vec_t;

  function automatic vec_t mk(input int d, input logic vld, input logic [23:0] dat, input logic [1:0] sel,
                              input logic md, input logic [3:0] ack, input logic clr, input logic e_rdy,
                              input logic [3:0] e_vld, input logic [3:0] e_ovf, input logic [1:0] e_rr,
                              input int e_ch, input logic [23:0] e_dat);
    vec_t v;
    v.d = d; v.vld = vld; v.dat = dat; v.sel = sel; v.md = md; v.ack = ack; v.clr = clr;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_ovf = e_ovf; v.e_rr = e_rr; v.e_ch = e_ch; v.e_dat = e_dat;
    return v;
  endfunction

  vec_t tv [19];

  initial begin
    int stalls;
    //          d vld dat       sel md ack    clr rdy vld     ovf     rr ch dat
    tv[0]  = mk(0, 1, 24'h000001, 0, 1, 4'b0000, 0, 1, 4'b0001, 4'b0000, 1, 0, 24'h000001);
    tv[1]  = mk(0, 1, 24'h000002, 0, 1, 4'b0000, 0, 1, 4'b0011, 4'b0000, 2, 1, 24'h000002);
    tv[2]  = mk(0, 1, 24'h000003, 0, 1, 4'b0000, 0, 1, 4'b0111, 4'b0000, 3, 2, 24'h000003);
    tv[3]  = mk(0, 1, 24'h000004, 0, 1, 4'b0000, 0, 1, 4'b1111, 4'b0000, 0, 3, 24'h000004);
    tv[4]  = mk(0, 1, 24'h000005, 0, 1, 4'b0000, 0, 0, 4'b1111, 4'b0000, 0, 0, 24'h000001);
    tv[5]  = mk(0, 1, 24'h000005, 0, 1, 4'b0001, 0, 1, 4'b1111, 4'b0000, 1, 0, 24'h000005);
    tv[6]  = mk(0, 0, 24'h000000, 0, 0, 4'b1111, 0, 1, 4'b0000, 4'b0000, 1, 0, 24'h000005);
    tv[7]  = mk(0, 1, 24'hABCDEF, 2, 0, 4'b0000, 0, 1, 4'b0100, 4'b0000, 1, 2, 24'hABCDEF);
    tv[8]  = mk(0, 0, 24'h000000, 2, 0, 4'b0100, 0, 1, 4'b0000, 4'b0000, 1, 2, 24'hABCDEF);
    tv[9]  = mk(0, 1, 24'h0F0F0F, 3, 0, 4'b0000, 0, 1, 4'b1000, 4'b0000, 1, 3, 24'h0F0F0F);
    tv[10] = mk(0, 1, 24'h123456, 3, 0, 4'b1000, 0, 1, 4'b1000, 4'b0000, 1, 3, 24'h123456);
    tv[11] = mk(0, 0, 24'h000000, 3, 0, 4'b1000, 0, 1, 4'b0000, 4'b0000, 1, 3, 24'h123456);
    tv[12] = mk(1, 1, 24'h111111, 1, 0, 4'b0000, 0, 1, 4'b0010, 4'b0000, 0, 1, 24'h111111);
    tv[13] = mk(1, 1, 24'h222222, 1, 0, 4'b0000, 0, 1, 4'b0010, 4'b0010, 0, 1, 24'h222222);
    tv[14] = mk(1, 1, 24'h333333, 1, 0, 4'b0000, 1, 1, 4'b0010, 4'b0010, 0, 1, 24'h333333);
    tv[15] = mk(1, 0, 24'h000000, 1, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000, 0, 1, 24'h333333);
    tv[16] = mk(1, 1, 24'h0F0F0F, 3, 0, 4'b0000, 0, 1, 4'b1010, 4'b0000, 0, 3, 24'h0F0F0F);
    tv[17] = mk(1, 1, 24'h123456, 3, 0, 4'b1000, 0, 1, 4'b1010, 4'b0000, 0, 3, 24'h123456);
    tv[18] = mk(1, 0, 24'h000000, 0, 0, 4'b1010, 0, 1, 4'b0000, 4'b0000, 0, 1, 24'h333333);

    rst = 1'b1;
    for (int d = 0; d < 2; d++) set_in(d, 0, 24'h0, 0, 0, 4'b0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset out_valid[d%0d]", d), {28'b0, ov[d]}, 32'h0);
      chk($sformatf("reset overflow[d%0d]", d), {28'b0, of[d]}, 32'h0);
      chk($sformatf("reset rr_ptr[d%0d]", d), {30'b0, rp[d]}, 32'h0);
      chk($sformatf("reset in_ready[d%0d]", d), {31'b0, rdy[d]}, 32'h1);
      chk($sformatf("reset out_data3[d%0d]", d), {8'b0, od[d][3]}, 32'h0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      int d;
      d = tv[i].d;
      set_in(1 - d, 0, 24'h0, 0, 0, 4'b0, 0);
      set_in(d, tv[i].vld, tv[i].dat, tv[i].sel, tv[i].md, tv[i].ack, tv[i].clr);
      cyc();
      chk($sformatf("vec%0d in_ready", i), {31'b0, rdy_seen[d]}, {31'b0, tv[i].e_rdy});
      chk($sformatf("vec%0d out_valid", i), {28'b0, ov[d]}, {28'b0, tv[i].e_vld});
      chk($sformatf("vec%0d overflow", i), {28'b0, of[d]}, {28'b0, tv[i].e_ovf});
      chk($sformatf("vec%0d rr_ptr", i), {30'b0, rp[d]}, {30'b0, tv[i].e_rr});
      chk($sformatf("vec%0d out_data%0d", i, tv[i].e_ch), {8'b0, od[d][tv[i].e_ch]}, {8'b0, tv[i].e_dat});
    end
    for (int d = 0; d < 2; d++) set_in(d, 0, 24'h0, 0, 0, 4'b0, 0);

    // Asynchronous reset between edges while channel 1 of d0 holds a sample.
    set_in(0, 1, 24'h777777, 0, 1, 4'b0, 0);
    cyc();
    set_in(0, 0, 24'h0, 0, 0, 4'b0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", {28'b0, ov[0]}, 32'h0);
    chk("async rst out_data1", {8'b0, od[0][1]}, 32'h0);
    chk("async rst rr_ptr", {30'b0, rp[0]}, 32'h0);
    chk("async rst overflow d1", {28'b0, of[1]}, 32'h0);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    set_in(0, 1, 24'hAAAAAA, 0, 1, 4'b0, 0);
    cyc();
    chk("post-reset sample in ch0", {8'b0, od[0][0]}, 32'h00AAAAAA);
    chk("post-reset out_valid", {28'b0, ov[0]}, 32'h1);

    // Round-robin wrap with every consumer acking.
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    stalls = 0;
    for (int i = 0; i < 9; i++) begin
      set_in(0, 1, 24'h000100 + 24'(i), 0, 1, 4'b1111, 0);
      cyc();
      if (!rdy_seen[0]) stalls++;
      chk($sformatf("wrap sample %0d ch%0d", i, i % 4), {8'b0, od[0][i % 4]}, 32'h100 + 32'(i));
    end
    chk("wrap stalls", 32'(stalls), 32'h0);
    chk("wrap final rr_ptr", {30'b0, rp[0]}, 32'h1);

    // Random traffic on both instances against the reference.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++)
        set_in(d, 1'($urandom_range(0, 3) != 0), 24'($urandom), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 4'($urandom & $urandom), 1'($urandom_range(0, 7) == 0));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_demux4.md
# sample_demux4

Four-channel sample distributor for the decimation filter output path: it takes one stream of 24-bit decimated samples and steers each sample into one of four per-channel holding registers. Channel selection is either explicit per sample or round-robin. Each channel holds its sample until its consumer acknowledges it. The block is the write-side counterpart of the 4:1 read-side selector: it fills the four 24-bit lanes that the selector later chooses between.

## Interface
Parameters:
- WIDTH, 24, sample width in bits.
- DROP, 0, full-channel policy: 0 = backpressure the source; 1 = never stall, overwrite the held sample and flag an overflow.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  source presents a sample.
- in_data  in  WIDTH  sample value.
- in_sel  in  2  target channel when mode = 0.
- mode  in  1  0 = addressed by in_sel, 1 = round-robin.
- in_ready  out  1  block accepts the sample this cycle; combinational.
- out_data0..out_data3  out  WIDTH  per-channel held sample, registered.
- out_valid  out  4  bit n set = channel n holds an unacknowledged sample.
- out_ack  in  4  bit n pulses to consume channel n.
- overflow  out  4  sticky; bit n set = an unacknowledged sample on channel n was overwritten (DROP = 1 only).
- clr_ovf  in  1  clears all overflow bits.
- rr_ptr  out  2  next round-robin target channel.

## Operation
- Target channel: tgt = mode ? rr_ptr : in_sel.
- in_ready:
  - DROP = 0: in_ready = !out_valid[tgt] | out_ack[tgt].
  - DROP = 1: in_ready = 1.
- Transfer: occurs when in_valid & in_ready.
  - On a transfer, out_data[tgt] <= in_data and out_valid[tgt] <= 1.
  - Only channel tgt changes; the other channels are unaffected.
- Ack handling:
  - out_ack[n] with no transfer to n in the same cycle: out_valid[n] <= 0. out_data[n] holds its last value.
  - out_ack[n] while out_valid[n] = 0: ignored.
  - out_ack[n] in the same cycle as a transfer to n: out_valid[n] stays 1, data takes the new sample, no overflow is flagged.
- Overflow (DROP = 1 only):
  - Set overflow[n] when a transfer to n happens while out_valid[n] = 1 and out_ack[n] = 0.
  - clr_ovf clears all four bits.
  - If clr_ovf and a set event occur in the same cycle, the set wins for that bit.
- Round-robin pointer:
  - In mode 1, rr_ptr increments on each transfer and wraps 3 -> 0.
  - In mode 0, rr_ptr holds its value.
  - A mode change does not reset rr_ptr.
  - A stalled cycle (in_valid & !in_ready) does not advance rr_ptr.
- Multiple acks in one cycle are allowed; each bit acts independently.
- out_ack bits for channels other than tgt never affect in_ready.

## Timing
- Reset (asynchronous assert, clocked release):
  - out_data0..3 = 0, out_valid = 0, overflow = 0, rr_ptr = 0.
  - in_ready evaluates to 1 after reset in both DROP modes.
- Latency: a sample accepted on edge k appears on out_data/out_valid after edge k; one cycle, fully registered.
- in_ready depends combinationally on mode, in_sel, rr_ptr, out_valid and out_ack. The source must not make in_valid depend on in_ready.
- Throughput: one sample per cycle.
  - Round-robin with all four consumers acking every cycle: no stalls.
  - DROP = 0 with tgt held valid and no ack: in_ready = 0 until an ack arrives.
- rst asserted mid-transfer: the sample is discarded. All state returns to reset values immediately, without waiting for clk.
- in_data, in_sel and mode are sampled only on transfer edges.

## Test plan
- Reset, then mode = 1, DROP = 0: send 0x000001..0x000004 back to back with no acks.
  - out_data0..3 = 1..4, out_valid = 4'b1111.
  - A fifth sample sees in_ready = 0 and rr_ptr = 0.
  - Pulse out_ack[0]: the fifth sample lands in ch0 the same cycle, and rr_ptr then = 1.
- Mode = 0, in_sel = 2, send 0xABCDEF.
  - Only out_valid[2] rises, one cycle after acceptance.
  - rr_ptr stays unchanged.
  - out_ack[2] clears out_valid[2] while out_data2 stays 0xABCDEF.
- DROP = 1, mode = 0, in_sel = 1: send 0x111111, then 0x222222 with no ack.
  - out_data1 = 0x222222, overflow = 4'b0010.
  - Assert clr_ovf in the same cycle as a third overwrite: overflow[1] stays 1.
  - A lone clr_ovf afterwards clears it.
- Same-cycle ack and write, channel 3 holding 0x0F0F0F: assert out_ack[3] with a transfer of 0x123456 to ch3.
  - out_valid[3] = 1, out_data3 = 0x123456, overflow[3] = 0 under either DROP value.
- Reset mid-stream: assert rst asynchronously between clock edges while valid data is held.
  - All outputs read 0 before the next edge.
  - The first post-reset sample in mode 1 lands in ch0.
- Round-robin wrap: with all acks tied high, send 9 samples.
  - Targets are ch0,1,2,3,0,1,2,3,0; final rr_ptr = 1; in_ready never deasserts.
